product_accumulator64: RTL and testbench
========================================

# product_accumulator64

Sequential multiply-accumulate back end for the 32x32 Wallace-tree multiplier. It consumes the multiplier's combinational 64-bit unsigned product as a valid/ready stream and sums a run of products terminated by a `last` flag, i.e. one dot product. It presents the 64-bit sum, a term count and an overflow flag on a registered valid/ready output. It sits directly downstream of the multiplier and upstream of any result FIFO or bus interface.

## Interface
- `CNT_W`, 16, width of term counter; saturates at all-ones.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `flush`  input  1  synchronous abort; discards the run in progress.
- `in_product`  input  64  unsigned product from the multiplier.
- `in_valid`  input  1  `in_product`/`in_last` valid.
- `in_last`  input  1  marks the final term of the current run.
- `in_ready`  output  1  block accepts a beat this cycle.
- `out_sum`  output  64  accumulated sum (registered).
- `out_count`  output  CNT_W  number of terms in the run (registered).
- `out_ovf`  output  1  sticky: an addition in the run carried out of bit 63.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.

## Operation
- Beat accepted ⇔ `in_valid && in_ready`. Result consumed ⇔ `out_valid && out_ready`.
- States:
  - IDLE: `in_ready=1`, `out_valid=0`.
  - ACCUM: `in_ready=1`, `out_valid=0`.
  - HOLD: `out_valid=1`, `in_ready=out_ready`.
- First beat of a run (accepted in IDLE, or in HOLD while the result is consumed): `acc<=in_product`, `cnt<=1`, `ovf<=0`. Next state is HOLD if `in_last`, else ACCUM.
- Accepted beat in ACCUM: `{carry,sum}=acc+in_product` (65-bit add); `acc<=sum`; `ovf<=ovf|carry`; `cnt<=cnt+1`, held at all-ones. Next state is HOLD if `in_last`, else ACCUM.
- HOLD, result consumed, no beat accepted: go to IDLE. Result not consumed: hold all outputs stable.
- `out_sum/out_count/out_ovf` drive `acc/cnt/ovf` directly from registers. They are meaningful only while `out_valid=1`.
- `flush=1`: forces `in_ready=0` and `out_valid=0` that cycle. The next state is IDLE and `acc/cnt/ovf` clear. `flush` wins over any simultaneous `in_valid` or `out_ready`.
- Arithmetic is unsigned modulo 2^64 unless the saturation feature is compiled in (see Configuration).

## Timing
- Reset values: state IDLE, `in_ready=0` while `rst=1`. After reset: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_count=0`, `out_ovf=0`.
- Latency: a `last` beat accepted at edge N gives `out_valid=1` from edge N onward, i.e. visible in the following cycle.
- Throughput: one beat per cycle. A HOLD→new run handoff with `out_ready=1` and `in_valid=1` creates no bubble.
- A single-term run (`in_last` on the first beat) is legal: result count is 1 and sum equals the product.
- `in_ready` in HOLD is combinational from `out_ready`. No other combinational input→output paths.
- `rst` mid-run or mid-HOLD: the run is lost and the block behaves as at reset. The result is never emitted.

## Configuration
- `PRODUCT_ACC_SATURATE_EN`
  - Defined: on any carry, or once `ovf=1`, `acc` is clamped to 64'hFFFF_FFFF_FFFF_FFFF for the rest of the run. `out_ovf` is still reported.
  - Undefined: `acc` wraps modulo 2^64 and `out_ovf` flags the wrap.

## Test plan
- Run of 3 beats: products 5, 7, 11 (last on 11), `out_ready=1` → one result with `out_sum=23`, `out_count=3`, `out_ovf=0`; `out_valid` one cycle after the last beat.
- Overflow: products 64'hFFFF_FFFF_FFFF_FFFF then 2 (last) → without macro: `out_sum=1`, `out_ovf=1`. With macro: `out_sum=64'hFFFF_FFFF_FFFF_FFFF`, `out_ovf=1`.
- Backpressure: result held with `out_ready=0` for 4 cycles while `in_valid=1` → `in_ready=0`, outputs stable. Then `out_ready=1` with a new single-term beat 9 → same-cycle handoff, next result `out_sum=9`, `out_count=1`.
- Flush: 2 beats accepted, then `flush=1` with `in_valid=1` → beat not accepted, no result emitted. Next run of product 4 (last) → `out_sum=4`, `out_count=1`.
- Reset mid-run: `rst` pulsed after 1 beat of a run → all outputs return to reset values. A following run of 3 (last) → `out_sum=3`.
- Counter saturation with `CNT_W=2`: 5 beats of value 1 → `out_count=3`, `out_sum=5`.

Source files
------------

// File: rtl/product_accumulator64.sv
//==============================================================================
// Module      : product_accumulator64
// Description : Multiply-accumulate back end that sums a valid/ready stream of
//               64-bit products into one dot-product result per 'last' run.
//               Optional macro PRODUCT_ACC_SATURATE_EN clamps the sum on carry.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module product_accumulator64 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [63:0]      in_product_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic [63:0]      out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [63:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              w_accept;
    logic              w_consume;
    logic [64:0]       w_sum_ext;
    logic [63:0]       w_acc_next;
    logic [CNT_W-1:0]  w_cnt_next;

    // in_ready in HOLD follows out_ready combinationally for a bubble-free handoff
    assign in_ready_o  = !rst && !flush_i && ((state_q != ST_HOLD) || out_ready_i);
    assign out_valid_o = (state_q == ST_HOLD) && !flush_i;
    assign out_sum_o   = acc_q;
    assign out_count_o = cnt_q;
    assign out_ovf_o   = ovf_q;

    assign w_accept  = in_valid_i && in_ready_o;
    assign w_consume = out_valid_o && out_ready_i;

    assign w_sum_ext  = {1'b0, acc_q} + {1'b0, in_product_i};
    assign w_cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

`ifdef PRODUCT_ACC_SATURATE_EN
    // Once any carry has occurred the sum stays pinned at all-ones for the run
    assign w_acc_next = (w_sum_ext[64] || ovf_q) ? {64{1'b1}} : w_sum_ext[63:0];
`else
    assign w_acc_next = w_sum_ext[63:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (flush_i) begin
            state_d = ST_IDLE;
            acc_d   = 64'd0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        acc_d   = in_product_i;
                        cnt_d   = CNT_ONE;
                        ovf_d   = 1'b0;
                        state_d = in_last_i ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        acc_d   = w_acc_next;
                        cnt_d   = w_cnt_next;
                        ovf_d   = ovf_q | w_sum_ext[64];
                        state_d = in_last_i ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (w_consume) begin
                        if (w_accept) begin
                            acc_d   = in_product_i;
                            cnt_d   = CNT_ONE;
                            ovf_d   = 1'b0;
                            state_d = in_last_i ? ST_HOLD : ST_ACCUM;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 64'd0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator64.sv
//==============================================================================
// Module      : tb_product_accumulator64
// Description : Directed self-checking bench for product_accumulator64.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_product_accumulator64;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [63:0] in_product;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [63:0] out_sum;
    logic [15:0] out_count;
    logic        out_ovf;
    logic        out_valid;

    logic        in_ready2;
    logic [63:0] out_sum2;
    logic [1:0]  out_count2;
    logic        out_ovf2;
    logic        out_valid2;

    int vectors;
    int miscompares;

    product_accumulator64 #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_product_i(in_product), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready), .out_sum_o(out_sum), .out_count_o(out_count),
        .out_ovf_o(out_ovf), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );

    // Narrow-counter instance shares stimulus to exercise count saturation
    product_accumulator64 #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_product_i(in_product), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready2), .out_sum_o(out_sum2), .out_count_o(out_count2),
        .out_ovf_o(out_ovf2), .out_valid_o(out_valid2), .out_ready_i(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] p, input logic last);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        tick();
        in_valid   = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_sum !== 64'd0) begin miscompares++; $display("FAIL post_rst_sum: got %0d want 0", out_sum); end
        vectors++; if (out_count !== 16'd0) begin miscompares++; $display("FAIL post_rst_count: got %0d want 0", out_count); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL post_rst_ovf: got %b want 0", out_ovf); end
    endtask

    task automatic test_run3();
        out_ready = 1'b1;
        send(64'd5, 1'b0);
        send(64'd7, 1'b0);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL run3_early_valid: got %b want 0", out_valid); end
        send(64'd11, 1'b1);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL run3_valid: got %b want 1", out_valid); end
        vectors++; if (out_sum !== 64'd23) begin miscompares++; $display("FAIL run3_sum: got %0d want 23", out_sum); end
        vectors++; if (out_count !== 16'd3) begin miscompares++; $display("FAIL run3_count: got %0d want 3", out_count); end
        vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL run3_ovf: got %b want 0", out_ovf); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL run3_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp_sum;
`ifdef PRODUCT_ACC_SATURATE_EN
        exp_sum = 64'hFFFF_FFFF_FFFF_FFFF;
`else
        exp_sum = 64'd1;
`endif
        out_ready = 1'b1;
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'd2, 1'b1);
        vectors++; if (out_sum !== exp_sum) begin miscompares++; $display("FAIL ovf_sum: got %h want %h", out_sum, exp_sum); end
        vectors++; if (out_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", out_ovf); end
        vectors++; if (out_count !== 16'd2) begin miscompares++; $display("FAIL ovf_count: got %0d want 2", out_count); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(64'd13, 1'b1);
        in_valid   = 1'b1;
        in_product = 64'd9;
        in_last    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++; if (out_sum !== 64'd13) begin miscompares++; $display("FAIL bp_sum[%0d]: got %0d want 13", i, out_sum); end
            vectors++; if (out_count !== 16'd1) begin miscompares++; $display("FAIL bp_count[%0d]: got %0d want 1", i, out_count); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_handoff_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_handoff_valid: got %b want 1", out_valid); end
        vectors++; if (out_sum !== 64'd9) begin miscompares++; $display("FAIL bp_handoff_sum: got %0d want 9", out_sum); end
        vectors++; if (out_count !== 16'd1) begin miscompares++; $display("FAIL bp_handoff_count: got %0d want 1", out_count); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(64'd100, 1'b0);
        send(64'd200, 1'b0);
        flush      = 1'b1;
        in_valid   = 1'b1;
        in_product = 64'd50;
        in_last    = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_result[%0d]: got %b want 0", i, out_valid); end
            tick();
        end
        vectors++; if (out_count !== 16'd0) begin miscompares++; $display("FAIL flush_count_clr: got %0d want 0", out_count); end
        send(64'd4, 1'b1);
        vectors++; if (out_sum !== 64'd4) begin miscompares++; $display("FAIL flush_next_sum: got %0d want 4", out_sum); end
        vectors++; if (out_count !== 16'd1) begin miscompares++; $display("FAIL flush_next_count: got %0d want 1", out_count); end
        tick();
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b1;
        send(64'd77, 1'b0);
        rst = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        vectors++; if (out_sum !== 64'd0) begin miscompares++; $display("FAIL midrst_sum: got %0d want 0", out_sum); end
        vectors++; if (out_count !== 16'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", out_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_back: got %b want 1", in_ready); end
        send(64'd3, 1'b1);
        vectors++; if (out_sum !== 64'd3) begin miscompares++; $display("FAIL midrst_next_sum: got %0d want 3", out_sum); end
        vectors++; if (out_count !== 16'd1) begin miscompares++; $display("FAIL midrst_next_count: got %0d want 1", out_count); end
        tick();
    endtask

    task automatic test_cnt_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(64'd1, 1'b0);
        send(64'd1, 1'b1);
        vectors++; if (out_count2 !== 2'd3) begin miscompares++; $display("FAIL sat_count_w2: got %0d want 3", out_count2); end
        vectors++; if (out_sum2 !== 64'd5) begin miscompares++; $display("FAIL sat_sum_w2: got %0d want 5", out_sum2); end
        vectors++; if (out_valid2 !== 1'b1) begin miscompares++; $display("FAIL sat_valid_w2: got %b want 1", out_valid2); end
        vectors++; if (out_count !== 16'd5) begin miscompares++; $display("FAIL sat_count_w16: got %0d want 5", out_count); end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst        = 1'b1;
        flush      = 1'b0;
        in_product = 64'd0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        test_reset();
        test_run3();
        test_overflow();
        test_backpressure();
        test_flush();
        test_reset_midrun();
        test_cnt_saturation();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
